forwarding_unit: RTL and testbench
==================================

# forwarding_unit

Tracks destination registers of instructions in flight through EX, MEM and WB using a small shadow pipeline. Drives the 2-bit `select` inputs of the two EX-stage operand forwarding muxes (operands A/rs and B/rt). Raises a load-use `stall` toward the IF/ID stage. Sits alongside the ID/EX boundary: it takes decode-stage register fields in and feeds the forwarding muxes.

## Interface
- `len_addr`, default 5: register address width.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: synchronous reset, active-low.
- `enable` input, 1 bit: pipeline advance; when 0 all state holds.
- `flush_ex` input, 1 bit: insert a bubble into EX at the next advance (branch taken).
- `id_rs`, `id_rt` inputs, `len_addr` bits each: source registers of the instruction in ID.
- `id_rd` input, `len_addr` bits: destination register after the RegDst choice.
- `id_reg_write`, `id_mem_read` inputs, 1 bit each: control bits of the instruction in ID.
- `select_a`, `select_b` outputs, 2 bits each: mux selects for the rs and rt operands in EX.
- `stall` output, 1 bit: load-use hazard; holds PC and IF/ID and bubbles EX.

## Operation
- Shadow stages:
  - EX: {rs, rt, rd, reg_write, mem_read}
  - MEM: {rd, reg_write}
  - WB: {rd, reg_write}
  - A bubble is all fields zero.
- Advance on a rising edge with `rst_n`=1 and `enable`=1:
  - WB←MEM
  - MEM←EX (rd, reg_write)
  - EX←bubble if `stall` or `flush_ex`, else EX←ID inputs.
- `enable`=0: every stage holds. Outputs are recomputed from the held state.
- Select encoding:
  - 00: register file
  - 01: MEM-stage ALU result
  - 10: WB mux output
  - 11: never driven
- `select_a` rules, in priority order:
  - 01 if MEM.reg_write, MEM.rd≠0 and MEM.rd==EX.rs;
  - else 10 if WB.reg_write, WB.rd≠0 and WB.rd==EX.rs;
  - else 00.
  - MEM has priority over WB, so the most recent producer wins.
- `select_b`: same rules using EX.rt.
- `stall` = EX.mem_read ∧ EX.rd≠0 ∧ (EX.rd==`id_rs` ∨ EX.rd==`id_rt`).
  - rt is compared unconditionally, which is conservative.
- Register $0 is never forwarded and never stalls.
- `stall` and `flush_ex` together: the outcome is a single bubble.
- Reset (`rst_n`=0 at an edge): all stages become bubbles, regardless of `enable`.

## Timing
- `select_a`, `select_b` and `stall` are combinational from stage registers and ID inputs. They are valid in the same cycle the instruction occupies EX/ID, with 0-cycle latency relative to stage state.
- Producer→consumer distance:
  - 1 instruction behind: 01
  - 2 behind: 10
  - 3 or more: 00 (register file is written first half, read second half).
- Load followed by a dependent instruction:
  - one `stall` cycle;
  - the dependent instruction then sees the load in MEM, so no forwarding from MEM for loads is needed.
  - It is then in EX with the load in WB → select 10.
- Outputs after reset: `select_a`=`select_b`=00, `stall`=0, from the first cycle after the reset edge.
- Reset asserted mid-stall clears `stall` at the next edge.

## Structure
- Shared package/header:
  - select encodings as named constants: `FW_REG`=00, `FW_MEM`=01, `FW_WB`=10;
  - the shadow-stage field layout.
  - The forwarding mux uses the same constants.
- Sub-module `fw_compare`: a pure combinational instance for one operand. Inputs are the source address and the MEM/WB {rd, reg_write}; output is the 2-bit select. Two instances are used.
- Stall logic and shadow registers are inline in `forwarding_unit`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with arbitrary ID inputs → selects 00 and `stall` 0; the first instruction after release sees 00.
- Back-to-back ALU dependencies:
  - `add $3,$1,$2`, then `sub $4,$3,$5` → in EX, `select_a`=01, `select_b`=00.
  - A third instruction `or $6,$5,$3` → `select_b`=10.
- Double producer: `add $3`, `add $3`, `and $7,$3,$3` → both selects 01 (MEM priority).
- Load-use:
  - `lw $8,0($1)`, then `add $9,$8,$2` → `stall`=1 for exactly one cycle, with a bubble in EX;
  - the add then reaches EX with `select_a`=10.
- $0 and flush:
  - a writer of $0 followed by a reader of $0 → selects 00;
  - `flush_ex` with `add $3`, then a reader of $3 → selects 00.
- Enable low for 3 cycles mid-dependency → selects and `stall` are unchanged throughout; the sequence resumes identically afterwards.

Source files
------------

// File: rtl/forwarding_unit_pkg.sv
// Shared definitions for the EX-stage operand forwarding logic.
// Select encodings are shared with the datapath forwarding muxes.
package forwarding_unit_pkg;

    localparam int LEN_ADDR_DEFAULT = 5;

    // Forwarding mux select encodings; 2'b11 is never driven.
    localparam logic [1:0] FW_REG = 2'b00;
    localparam logic [1:0] FW_MEM = 2'b01;
    localparam logic [1:0] FW_WB  = 2'b10;

    // Shadow-stage field order, MSB first:
    //   EX  stage: {rs, rt, rd, reg_write, mem_read}
    //   MEM stage: {rd, reg_write}
    //   WB  stage: {rd, reg_write}
    // A bubble is every field zero.
    localparam int EX_FIELD_COUNT  = 5;
    localparam int MWB_FIELD_COUNT = 2;

    // The most recent producer wins, so a MEM hit outranks a WB hit.
    function automatic logic [1:0] fw_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FW_MEM;
        end
        if (wb_hit) begin
            return FW_WB;
        end
        return FW_REG;
    endfunction

endpackage

// File: rtl/forwarding_unit_compare.sv
// Combinational forwarding select for a single EX-stage source operand.
// Register $0 is hard-wired to zero and is never forwarded.
module fw_compare
    import forwarding_unit_pkg::*;
#(
    parameter int len_addr = LEN_ADDR_DEFAULT
) (
    input  logic [len_addr-1:0] src,
    input  logic [len_addr-1:0] mem_rd,
    input  logic                mem_reg_write,
    input  logic [len_addr-1:0] wb_rd,
    input  logic                wb_reg_write,
    output logic [1:0]          select
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
        wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);
        select  = fw_pick(mem_hit, wb_hit);
    end

endmodule

// File: rtl/forwarding_unit.sv
// Shadow EX/MEM/WB destination tracking, operand forwarding selects and
// load-use stall generation for a classic five-stage pipeline.
module forwarding_unit
    import forwarding_unit_pkg::*;
#(
    parameter int len_addr = LEN_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                flush_ex,
    input  logic [len_addr-1:0] id_rs,
    input  logic [len_addr-1:0] id_rt,
    input  logic [len_addr-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    output logic [1:0]          select_a,
    output logic [1:0]          select_b,
    output logic                stall
);

    typedef struct packed {
        logic [len_addr-1:0] rs;
        logic [len_addr-1:0] rt;
        logic [len_addr-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic [len_addr-1:0] rd;
        logic                reg_write;
    } mwb_stage_t;

    ex_stage_t  ex_q;
    mwb_stage_t mem_q;
    mwb_stage_t wb_q;
    ex_stage_t  id_stage;

    always_comb begin
        id_stage.rs        = id_rs;
        id_stage.rt        = id_rt;
        id_stage.rd        = id_rd;
        id_stage.reg_write = id_reg_write;
        id_stage.mem_read  = id_mem_read;
    end

    // rt is compared even for instructions that do not read it: conservative.
    always_comb begin
        stall = ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (enable) begin
            wb_q            <= mem_q;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            // A stall and a flush in the same cycle still yield one bubble.
            ex_q            <= (stall || flush_ex) ? '0 : id_stage;
        end
    end

    fw_compare #(.len_addr(len_addr)) u_cmp_a (
        .src           (ex_q.rs),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .select        (select_a)
    );

    fw_compare #(.len_addr(len_addr)) u_cmp_b (
        .src           (ex_q.rt),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .select        (select_b)
    );

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: a driver pushes the hand-computed
// {select_a, select_b, stall} for each cycle; a negedge monitor pops and compares.
module tb_forwarding_unit;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       flush_ex;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [1:0] select_a;
    logic [1:0] select_b;
    logic       stall;

    logic [4:0] exp_q[$];
    string      tag_q[$];
    logic       chk_pending;
    logic       en_next;
    logic       rst_next;
    int         checks;
    int         errors;

    forwarding_unit #(.len_addr(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush_ex     (flush_ex),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .select_a     (select_a),
        .select_b     (select_b),
        .stall        (stall)
    );

    // Clock and reset-time defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply one ID-stage instruction 1 time unit after the edge and
    // record the outputs expected for that cycle.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl,
                         input logic [1:0] ea, input logic [1:0] eb, input logic es,
                         input string tag);
        @(posedge clk);
        #1;
        rst_n        = rst_next;
        enable       = en_next;
        flush_ex     = fl;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        exp_q.push_back({ea, eb, es});
        tag_q.push_back(tag);
        chk_pending  = 1'b1;
    endtask

    task automatic nop(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                       input string tag);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, es, tag);
    endtask

    // Monitor / scoreboard: outputs are valid every cycle once inputs settle.
    always @(negedge clk) begin
        if (chk_pending) begin
            logic [4:0] exp_v;
            string      tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            checks++;
            if ({select_a, select_b, stall} !== exp_v) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b stall=%b, expected a=%b b=%b stall=%b",
                         tag, select_a, select_b, stall, exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
            chk_pending = 1'b0;
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        chk_pending  = 1'b0;
        rst_n        = 1'b0;
        enable       = 1'b1;
        flush_ex     = 1'b0;
        id_rs        = 5'd3;
        id_rt        = 5'd3;
        id_rd        = 5'd3;
        id_reg_write = 1'b1;
        id_mem_read  = 1'b1;
        en_next      = 1'b1;
        rst_next     = 1'b0;

        // Reset held for two cycles with a load-like instruction in ID
        drive(5'd3, 5'd3, 5'd3, 1, 1, 0, 2'b00, 2'b00, 0, "reset_c1");
        drive(5'd7, 5'd3, 5'd3, 1, 1, 0, 2'b00, 2'b00, 0, "reset_c2");
        rst_next = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5 ; or $6,$5,$3
        drive(5'd1, 5'd2, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, "first_after_reset");
        drive(5'd3, 5'd5, 5'd4, 1, 0, 0, 2'b00, 2'b00, 0, "add_in_ex");
        drive(5'd5, 5'd3, 5'd6, 1, 0, 0, 2'b01, 2'b00, 0, "sub_fwd_mem");
        nop(2'b00, 2'b10, 0, "or_fwd_wb");
        nop(2'b00, 2'b00, 0, "drain_1");

        // Double producer of $3 then and $7,$3,$3
        drive(5'd1, 5'd2, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, "dbl_add1");
        drive(5'd1, 5'd2, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, "dbl_add2");
        drive(5'd3, 5'd3, 5'd7, 1, 0, 0, 2'b00, 2'b00, 0, "dbl_and_id");
        nop(2'b01, 2'b01, 0, "dbl_mem_priority");
        nop(2'b00, 2'b00, 0, "drain_2");
        nop(2'b00, 2'b00, 0, "drain_3");

        // lw $8,0($1) ; add $9,$8,$2
        drive(5'd1, 5'd8, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "lw_in_id");
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, "load_use_stall");
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, "stall_one_cycle");
        nop(2'b10, 2'b00, 0, "load_fwd_wb");
        nop(2'b00, 2'b00, 0, "drain_4");
        nop(2'b00, 2'b00, 0, "drain_5");

        // Writer of $0, reader of $0, load to $0
        drive(5'd1, 5'd2, 5'd0, 1, 0, 0, 2'b00, 2'b00, 0, "zero_writer");
        drive(5'd0, 5'd0, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, "zero_reader_id");
        nop(2'b00, 2'b00, 0, "zero_no_mem_fwd");
        drive(5'd1, 5'd0, 5'd0, 1, 1, 0, 2'b00, 2'b00, 0, "lw_zero_id");
        drive(5'd0, 5'd0, 5'd10, 1, 0, 0, 2'b00, 2'b00, 0, "lw_zero_no_stall");
        nop(2'b00, 2'b00, 0, "zero_lw_no_fwd");
        nop(2'b00, 2'b00, 0, "drain_6");
        nop(2'b00, 2'b00, 0, "drain_7");

        // Flushed add $3 followed by a reader of $3
        drive(5'd1, 5'd2, 5'd3, 1, 0, 1, 2'b00, 2'b00, 0, "flush_add");
        drive(5'd3, 5'd3, 5'd6, 1, 0, 0, 2'b00, 2'b00, 0, "flush_reader_id");
        nop(2'b00, 2'b00, 0, "flush_no_fwd");
        nop(2'b00, 2'b00, 0, "drain_8");

        // Enable low for 3 cycles with a MEM forward pending
        drive(5'd1, 5'd2, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, "en_add");
        drive(5'd3, 5'd5, 5'd4, 1, 0, 0, 2'b00, 2'b00, 0, "en_sub");
        en_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd3, 5'd6, 1, 0, 0, 2'b01, 2'b00, 0, "en_hold_fwd");
        end
        en_next = 1'b1;
        drive(5'd5, 5'd3, 5'd6, 1, 0, 0, 2'b01, 2'b00, 0, "en_resume_mem");
        nop(2'b00, 2'b10, 0, "en_resume_wb");
        nop(2'b00, 2'b00, 0, "drain_9");

        // Enable low for 3 cycles during a load-use stall
        drive(5'd1, 5'd8, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "en_lw");
        en_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, "en_hold_stall");
        end
        en_next = 1'b1;
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, "en_stall_resume");
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, "en_stall_bubble");
        nop(2'b10, 2'b00, 0, "en_load_fwd_wb");
        nop(2'b00, 2'b00, 0, "drain_10");

        // Reset asserted while a stall is showing
        drive(5'd1, 5'd8, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "rst_lw");
        rst_next = 1'b0;
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, "rst_stall_shown");
        rst_next = 1'b1;
        drive(5'd8, 5'd2, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, "rst_clears_stall");
        nop(2'b00, 2'b00, 0, "rst_clears_stages");

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
